mc_core: RTL

MC_CORE -- requirements
Module: mc_core

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/mc_core_if.sv | 18 +
 rtl/alu.sv | 24 ++
 rtl/extend.sv | 24 ++
 rtl/mc_controller.sv | 190 +++++++++++++++++++
 rtl/regfile.sv | 31 +++
 rtl/mc_core.sv | 121 ++++++++++++
 7 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle core: FSM states, ALU and
// immediate-format encodings, opcodes, and the ALU-op decode helper.
package cpu_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // funct3 -> ALU operation; 'sub' selects SUB over ADD (R-type only).
  function automatic alu_ctrl_t alu_decode(input logic [2:0] funct3, input logic sub);
    case (funct3)
      3'b000:  alu_decode = sub ? ALU_SUB : ALU_ADD;
      3'b111:  alu_decode = ALU_AND;
      3'b110:  alu_decode = ALU_OR;
      3'b010:  alu_decode = ALU_SLT;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_core_if.sv
// Unified memory port of the core.
// Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata and
// holds them unchanged until the slave answers with mem_ready in the same
// cycle; that cycle completes the transfer and, for reads, mem_rdata is
// valid only in that cycle. mem_ready is ignored while mem_req is low.
interface mc_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/alu.sv
// 32-bit ALU: wrapping add/sub, bitwise and/or, signed set-less-than.
module alu
  import cpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_ctrl_t   ctrl_i,
  output logic [31:0] y_o
);

  // Pure combinational operation select.
  always_comb begin
    y_o = '0;
    case (ctrl_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_SLT: y_o = {31'b0, $signed(a_i) < $signed(b_i)};
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/extend.sv
// Immediate generator for I, S, B and J formats, sign-extended to 32 bits.
module extend
  import cpu_pkg::*;
(
  input  logic [31:7] instr_i,
  input  imm_src_t    imm_src_i,
  output logic [31:0] imm_o
);

  // Reassemble the immediate bits for the selected format.
  always_comb begin
    imm_o = '0;
    case (imm_src_i)
      IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle FSM plus instruction decode. Drives the memory port directly
// and produces the datapath enables/selects for each state.
module mc_controller
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr_i,
  input  logic        eq_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] result_i,
  input  logic [31:0] wdata_i,
  mc_core_if.master   mem,
  output state_t      state_o,
  output logic        instr_en_o,
  output logic        data_en_o,
  output logic        result_en_o,
  output logic        result_pc4_o,
  output logic        alu_src_imm_o,
  output alu_ctrl_t   alu_ctrl_o,
  output imm_src_t    imm_src_o,
  output logic        reg_write_o,
  output logic        wd_data_o,
  output logic        pc_en_o,
  output logic        pc_target_o,
  output logic        retire_o
);

  state_t state_q, state_d;
  state_t dec_state;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic use_rd, use_rs1, use_rs2;
  logic is_sw, is_jal;
  logic req_c, we_c, addr_data_c, retire_c;

  assign opcode  = instr_i[6:0];
  assign funct3  = instr_i[14:12];
  assign funct7  = instr_i[31:25];
  assign is_sw   = (opcode == OP_STORE);
  assign is_jal  = (opcode == OP_JAL);
  assign state_o = state_q;

  // Decode: pick the state after DECODE; anything unrecognised halts.
  always_comb begin
    dec_state = HALT;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (opcode)
      OP_LOAD: if (funct3 == 3'b010) begin
        dec_state = MEMADR; use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_STORE: if (funct3 == 3'b010) begin
        dec_state = MEMADR; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_RTYPE: if ((funct7 == 7'b0000000 && funct3 inside {3'b000, 3'b111, 3'b110, 3'b010}) ||
                    (funct7 == 7'b0100000 && funct3 == 3'b000)) begin
        dec_state = EXECUTER; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_ITYPE: if (funct3 inside {3'b000, 3'b111, 3'b110, 3'b010}) begin
        dec_state = EXECUTEI; use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_BRANCH: if (funct3 == 3'b000) begin
        dec_state = BEQ; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_JAL: begin
        dec_state = JAL; use_rd = 1'b1;
      end
      default: dec_state = HALT;
    endcase
    // RV32E: only x0..x15 exist; bit 4 of any used index is illegal.
    if ((NUM_REGS == 16) &&
        ((use_rd && instr_i[11]) || (use_rs1 && instr_i[19]) || (use_rs2 && instr_i[24]))) begin
      dec_state = HALT;
    end
  end

  // Next state and per-state control outputs.
  always_comb begin
    state_d       = state_q;
    req_c         = 1'b0;
    we_c          = 1'b0;
    addr_data_c   = 1'b0;
    retire_c      = 1'b0;
    instr_en_o    = 1'b0;
    data_en_o     = 1'b0;
    result_en_o   = 1'b0;
    result_pc4_o  = 1'b0;
    alu_src_imm_o = 1'b0;
    alu_ctrl_o    = ALU_ADD;
    imm_src_o     = IMM_I;
    reg_write_o   = 1'b0;
    wd_data_o     = 1'b0;
    pc_en_o       = 1'b0;
    pc_target_o   = 1'b0;
    case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (mem.mem_ready) begin
          instr_en_o = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: state_d = dec_state;
      MEMADR: begin
        alu_src_imm_o = 1'b1;
        imm_src_o     = is_sw ? IMM_S : IMM_I;
        result_en_o   = 1'b1;
        state_d       = is_sw ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        req_c       = 1'b1;
        addr_data_c = 1'b1;
        if (mem.mem_ready) begin
          data_en_o = 1'b1;
          state_d   = MEMWB;
        end
      end
      MEMWB: begin
        reg_write_o = 1'b1;
        wd_data_o   = 1'b1;
        pc_en_o     = 1'b1;
        retire_c    = 1'b1;
        state_d     = FETCH;
      end
      MEMWRITE: begin
        req_c       = 1'b1;
        we_c        = 1'b1;
        addr_data_c = 1'b1;
        if (mem.mem_ready) begin
          pc_en_o  = 1'b1;
          retire_c = 1'b1;
          state_d  = FETCH;
        end
      end
      EXECUTER: begin
        alu_ctrl_o  = alu_decode(funct3, funct7[5]);
        result_en_o = 1'b1;
        state_d     = ALUWB;
      end
      EXECUTEI: begin
        alu_src_imm_o = 1'b1;
        alu_ctrl_o    = alu_decode(funct3, 1'b0);
        result_en_o   = 1'b1;
        state_d       = ALUWB;
      end
      JAL: begin
        result_en_o  = 1'b1;
        result_pc4_o = 1'b1;
        state_d      = ALUWB;
      end
      ALUWB: begin
        reg_write_o = 1'b1;
        imm_src_o   = is_jal ? IMM_J : IMM_I;
        pc_target_o = is_jal;
        pc_en_o     = 1'b1;
        retire_c    = 1'b1;
        state_d     = FETCH;
      end
      BEQ: begin
        imm_src_o   = IMM_B;
        pc_target_o = eq_i;
        pc_en_o     = 1'b1;
        retire_c    = 1'b1;
        state_d     = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Reset abandons any transfer immediately, so request and retire are
  // masked combinationally while reset is asserted.
  assign mem.mem_req   = req_c & ~reset;
  assign mem.mem_we    = we_c;
  assign mem.mem_addr  = addr_data_c ? {result_i[31:2], 2'b00} : {pc_i[31:2], 2'b00};
  assign mem.mem_wdata = wdata_i;
  assign retire_o      = retire_c & ~reset;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

endmodule

// File: rtl/regfile.sv
// Two-read, one-write register file. x0 reads as zero and ignores writes.
// Reads are combinational from the array, so a same-cycle write is seen
// only after the clock edge. Contents are not reset.
module regfile #(
  parameter int NUM_REGS = 32
) (
  input  logic        clock,
  input  logic        we_i,
  input  logic [4:0]  a1_i,
  input  logic [4:0]  a2_i,
  input  logic [4:0]  a3_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  localparam int AW = $clog2(NUM_REGS);

  logic [31:0] regs_q [NUM_REGS];

  assign rd1_o = (a1_i[AW-1:0] == '0) ? '0 : regs_q[a1_i[AW-1:0]];
  assign rd2_o = (a2_i[AW-1:0] == '0) ? '0 : regs_q[a2_i[AW-1:0]];

  // Write port; x0 is never stored.
  always_ff @(posedge clock) begin
    if (we_i && (a3_i[AW-1:0] != '0)) begin
      regs_q[a3_i[AW-1:0]] <= wd_i;
    end
  end

endmodule

// File: rtl/mc_core.sv
// Multicycle RV32I/RV32E core top: PC, instruction, load-data and result
// registers around the shared ALU, register file and immediate generator.
module mc_core
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted
);

  mc_core_if mem_bus ();

  logic [31:0] pc_q, pc_d, instr_q, instr_d, data_q, data_d, result_q, result_d;
  logic [31:0] rd1, rd2, imm, alu_b, alu_y, pc_plus4, pc_target, wd;
  state_t      ctrl_state;
  logic        instr_en, data_en, result_en, result_pc4, alu_src_imm;
  logic        reg_write, wd_data, pc_en, pc_target_sel;
  alu_ctrl_t   alu_ctrl;
  imm_src_t    imm_src;

  assign mem_bus.mem_rdata = mem_rdata;
  assign mem_bus.mem_ready = mem_ready;
  assign mem_req           = mem_bus.mem_req;
  assign mem_we            = mem_bus.mem_we;
  assign mem_addr          = mem_bus.mem_addr;
  assign mem_wdata         = mem_bus.mem_wdata;

  mc_controller #(.NUM_REGS(NUM_REGS)) u_ctrl (
    .clock         (clock),
    .reset         (reset),
    .instr_i       (instr_q),
    .eq_i          (rd1 == rd2),
    .pc_i          (pc_q),
    .result_i      (result_q),
    .wdata_i       (rd2),
    .mem           (mem_bus),
    .state_o       (ctrl_state),
    .instr_en_o    (instr_en),
    .data_en_o     (data_en),
    .result_en_o   (result_en),
    .result_pc4_o  (result_pc4),
    .alu_src_imm_o (alu_src_imm),
    .alu_ctrl_o    (alu_ctrl),
    .imm_src_o     (imm_src),
    .reg_write_o   (reg_write),
    .wd_data_o     (wd_data),
    .pc_en_o       (pc_en),
    .pc_target_o   (pc_target_sel),
    .retire_o      (retire)
  );

  regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clock (clock),
    .we_i  (reg_write),
    .a1_i  (instr_q[19:15]),
    .a2_i  (instr_q[24:20]),
    .a3_i  (instr_q[11:7]),
    .wd_i  (wd),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  extend u_extend (
    .instr_i   (instr_q[31:7]),
    .imm_src_i (imm_src),
    .imm_o     (imm)
  );

  alu u_alu (
    .a_i    (rd1),
    .b_i    (alu_b),
    .ctrl_i (alu_ctrl),
    .y_o    (alu_y)
  );

  assign alu_b     = alu_src_imm ? imm : rd2;
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_target = pc_q + imm;
  assign wd        = wd_data ? data_q : result_q;
  assign pc        = pc_q;
  assign halted    = (ctrl_state == HALT);

  // Next values of the datapath registers, gated by controller enables.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    data_d   = data_q;
    result_d = result_q;
    if (pc_en)     pc_d     = pc_target_sel ? pc_target : pc_plus4;
    if (instr_en)  instr_d  = mem_bus.mem_rdata;
    if (data_en)   data_d   = mem_bus.mem_rdata;
    if (result_en) result_d = result_pc4 ? pc_plus4 : alu_y;
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      data_q   <= data_d;
      result_q <= result_d;
    end
  end

endmodule
